// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one multiplier between two requesters, with a timeout.
module mul_arbiter #(
  parameter int TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] res,
  output logic       busy,
  output logic       mul_start,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic       mul_valid,
  input  logic [7:0] mul_product
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic id, last, win, hit, ok, tmo;
  always_comb begin
    win = (req0 & req1) ? ~last : req1;
    hit = cnt == 6'(TIMEOUT - 1);
    ok  = state == WAIT && mul_valid;
    tmo = state == WAIT && !mul_valid && hit;
    state_nx = state == IDLE  ? ((req0 | req1) ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? ((ok | tmo) ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= state_nx;
  // last holds the most recently served requester; reset value 1 gives requester 0 priority
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      cnt <= '0;
      id <= 1'b0;
      last <= 1'b1;
      res <= '0;
      mul_a <= '0;
      mul_b <= '0;
      busy <= 1'b0;
      mul_start <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 6'd1 : '0;
      busy <= state_nx != IDLE;
      mul_start <= state_nx == ISSUE;
      done0 <= ok & ~id;
      done1 <= ok & id;
      err0 <= tmo & ~id;
      err1 <= tmo & id;
      if (state == IDLE && (req0 | req1)) begin
        id <= win;
        mul_a <= win ? a1 : a0;
        mul_b <= win ? b1 : b0;
      end
      if (ok) res <= mul_product;
      if (state == RESP) last <= id;
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: randomized scoreboard bench for mul_arbiter against a transaction-level model.
module tb_mul_arbiter;
  localparam int TIMEOUT = 20;
  logic clk = 0, n_rst = 0;
  logic req0 = 0, req1 = 0;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic done0, done1, err0, err1, busy, mul_start;
  logic [7:0] res;
  logic [3:0] mul_a, mul_b;
  logic mul_valid;
  logic [7:0] mul_product;

  mul_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .res(res), .busy(busy), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid(mul_valid), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  typedef struct {bit id; logic [3:0] a; logic [3:0] b; int d; logic [7:0] r;} exp_t;
  exp_t exp_q[$];
  int dly_q[$];
  logic [7:0] pa0[$], pa1[$];
  bit last_m = 1;
  logic [7:0] res_m = 0;
  int n_cmp = 0, n_err = 0;
  bit stray = 0;
  logic [7:0] stray_p = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // multiplier model: answers in WAIT cycle d (d==0 never answers), plus stray pulses on demand
  initial begin
    int cnt;
    cnt = 0;
    mul_valid = 0;
    mul_product = 0;
    forever begin
      @(posedge clk);
      #1;
      mul_valid = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mul_valid = 1;
          mul_product = 8'(mul_a) * 8'(mul_b);
        end
      end
      if (stray) begin
        mul_valid = 1;
        mul_product = stray_p;
        stray = 0;
      end
      if (mul_start && n_rst) cnt = dly_q.size() ? dly_q.pop_front() : 0;
    end
  end

  // monitor: compares every start and every completion against the head of the scoreboard
  int cyc = 0, start_cyc = 0;
  bit post_resp = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (n_rst) begin
      if (post_resp) chk("post_resp", {busy, done0, done1, err0, err1}, 0);
      post_resp = 0;
      if (mul_start) begin
        chk("start_has_op", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("start_ops", {mul_a, mul_b}, {exp_q[0].a, exp_q[0].b});
        start_cyc = cyc;
      end
      if (done0 | done1 | err0 | err1) begin
        chk("resp_has_op", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("resp_single", $countones({done0, done1, err0, err1}), 1);
          chk("resp_id", done1 | err1, e.id);
          chk("resp_err", err0 | err1, e.d == 0);
          chk("resp_res", res, e.r);
          chk("resp_hold_ops", {mul_a, mul_b}, {e.a, e.b});
          chk("resp_latency", cyc - start_cyc, e.d == 0 ? TIMEOUT + 1 : e.d + 1);
          post_resp = 1;
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: run did not end, queue %0d expected 0", exp_q.size());
    $fatal(1);
  end

  task automatic chk_reset_outs(input string nm);
    chk(nm, {busy, mul_start, done0, done1, err0, err1, res, mul_a, mul_b}, 0);
  endtask

  task automatic wait_resp(input bit id);
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (id ? (done1 | err1) : (done0 | err0)) break;
    end
    chk(id ? "wait_resp1" : "wait_resp0", k < 400, 1);
  endtask

  int pick_d;
  task automatic run_batch(input int fixed_d);
    int r0, r1, i0, i1, d;
    bit w;
    logic [7:0] op;
    r0 = pa0.size(); r1 = pa1.size(); i0 = 0; i1 = 0;
    while (r0 + r1 > 0) begin
      w = (r0 > 0 && r1 > 0) ? !last_m : (r0 == 0);
      last_m = w;
      if (w) begin op = pa1[i1]; i1++; r1--; end
      else begin op = pa0[i0]; i0++; r0--; end
      if (fixed_d >= 0) d = fixed_d;
      else begin
        pick_d = $urandom_range(0, 9);
        d = pick_d == 0 ? 0 : pick_d == 1 ? TIMEOUT : $urandom_range(1, TIMEOUT);
      end
      if (d != 0) res_m = op[7:4] * op[3:0];
      dly_q.push_back(d);
      exp_q.push_back('{w, op[7:4], op[3:0], d, res_m});
    end
    fork
      for (int k = 0; k < pa0.size(); k++) begin
        {a0, b0} = pa0[k];
        req0 = 1;
        wait_resp(0);
        req0 = 0;
      end
      for (int k = 0; k < pa1.size(); k++) begin
        {a1, b1} = pa1[k];
        req1 = 1;
        wait_resp(1);
        req1 = 0;
      end
      begin
        int k;
        k = 0;
        while (!mul_start && k < 5) begin @(posedge clk); #1; k++; end
        chk("grant_latency", k, 1);
      end
    join
    pa0.delete();
    pa1.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 0;
    #1;
    chk_reset_outs("reset_outs");
    res_m = 0;
    last_m = 1;
    @(negedge clk);
    n_rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic stray_pulse(input logic [7:0] p);
    stray_p = p;
    stray = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_res", res, res_m);
    chk("stray_busy", busy, 0);
  endtask

  initial begin
    #12;
    chk_reset_outs("reset_outs");
    @(negedge clk);
    n_rst = 1;
    @(posedge clk);
    #1;
    pa0.push_back({4'd5, 4'd9});
    run_batch(3);
    do_reset();
    pa0.push_back({4'd4, 4'd7});
    pa1.push_back({4'd2, 4'd8});
    run_batch(2);
    repeat (2) pa0.push_back(8'($urandom));
    repeat (3) pa1.push_back(8'($urandom));
    run_batch(-1);
    pa1.push_back({4'd9, 4'd9});
    run_batch(0);
    pa0.push_back({4'd15, 4'd15});
    run_batch(TIMEOUT);
    // reset in the middle of WAIT: the operation must vanish
    exp_q.push_back('{1, 4'd3, 4'd6, 0, 8'd0});
    dly_q.push_back(0);
    {a1, b1} = {4'd3, 4'd6};
    req1 = 1;
    repeat (5) @(posedge clk);
    #3;
    n_rst = 0;
    #1;
    chk_reset_outs("mid_wait_reset");
    void'(exp_q.pop_front());
    res_m = 0;
    last_m = 1;
    req1 = 0;
    @(negedge clk);
    n_rst = 1;
    @(posedge clk);
    #1;
    stray_pulse(8'h51);
    for (int t = 0; t < 25; t++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = (n0 == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
      repeat (n0) pa0.push_back(8'($urandom));
      repeat (n1) pa1.push_back(8'($urandom));
      run_batch(-1);
      if (t % 4 == 0) stray_pulse(8'($urandom));
    end
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 20: max cycles in WAIT before abort; legal range 2..63.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  requester 0/1 request; held high with operands stable until done or err.
REQ-005 a0, b0, a1, b1  input  4 each  requester operands (a = multiplier_1, b = multiplicand).
REQ-006 done0, done1  output  1 each  one-cycle completion pulse to requester.
REQ-007 err0, err1  output  1 each  one-cycle timeout pulse to requester.
REQ-008 res  output  8  result of most recent completed operation; valid while done0/done1 high, held afterwards.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 mul_start  output  1  start pulse to the shared multiplier.
REQ-011 mul_a, mul_b  output  4 each  operands to multiplier_1 / multiplicand.
REQ-012 mul_valid  input  1  multiplier completion strobe.
REQ-013 mul_product  input  8  multiplier result, qualified by mul_valid.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-015 IDLE: req0/req1 sampled only here; any request -> ISSUE next edge; none -> stay IDLE.
REQ-016 Arbitration round-robin: single request wins; both high -> the requester not granted last wins; after reset, requester 0 holds priority.
REQ-017 On the grant edge: latch winner's operands into mul_a/mul_b; record winner id in a 1-bit register.
REQ-018 ISSUE: mul_start high for exactly this one cycle; -> WAIT unconditionally.
REQ-019 mul_a/mul_b SHALL hold stable from ISSUE until return to IDLE.
REQ-020 WAIT: 6-bit counter cleared on ISSUE entry, incremented each WAIT cycle.
REQ-021 WAIT, mul_valid high: res <= mul_product; -> RESP.
REQ-022 WAIT, counter reaches TIMEOUT with mul_valid low: -> RESP flagged as error; res unchanged.
REQ-023 mul_valid in same cycle as counter reaching TIMEOUT: success takes priority.
REQ-024 mul_valid outside WAIT: ignored, no state or res change.
REQ-025 RESP: one-cycle pulse on done or err of winner only; other requester's outputs stay low; round-robin pointer updated to winner; -> IDLE.
REQ-026 Latency: req high on IDLE edge N -> mul_start high cycle N+1 -> done pulse exactly one cycle after the edge that sampled mul_valid.
REQ-027 Requester deasserts req on the edge it sees done/err; a req still high in IDLE is a new request.
REQ-028 Losing requester keeps req high and is served next; no request lost or duplicated.
REQ-029 res is 8-bit, no truncation; max 15*15 = 225 (0xE1).

Reset
REQ-030 n_rst low: immediately state IDLE, counter 0, pointer favours requester 0, res 0x00, mul_a/mul_b 0x0, mul_start/done0/done1/err0/err1/busy 0.
REQ-031 Reset during ISSUE/WAIT/RESP: operation discarded; no done/err issued afterwards; a later mul_valid is ignored in IDLE.
REQ-032 After n_rst rises, first request accepted on the first rising edge with req high.

Verification
REQ-033 req0, a0=5, b0=9, multiplier returns 0x2D -> one mul_start pulse, mul_a=5, mul_b=9, done0 one cycle, res=0x2D, done1/err low.
REQ-034 req0 and req1 same cycle after reset (4*7, 2*8) -> requester 0 served first (res=0x1C, done0), then requester 1 (res=0x10, done1); two mul_start pulses total.
REQ-035 Both requesters re-request continuously, 4 ops -> grants alternate 1,0,1,0 after the initial 0 win.
REQ-036 req1, a1=9, b1=9, mul_valid never asserted, TIMEOUT=20 -> err1 pulses 20 WAIT cycles after ISSUE, res unchanged, busy low next cycle.
REQ-037 n_rst low mid-WAIT, then stray mul_valid with 0x51 -> all outputs at reset values, no done, res stays 0x00.
REQ-038 mul_valid on exactly the TIMEOUT cycle with product 0xE1 (15*15) -> done pulses, err stays low, res=0xE1.
